// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the single-port RAM arbiter: ownership, FSM state and
// the legal parameter limits.
package mem_port_arbiter_pkg;

  localparam int unsigned ARB_MAX_LATENCY = 4;
  localparam int unsigned ARB_MAX_STREAK  = 15;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and
// load/store. One transaction in flight; data has priority, with a streak
// limiter that forces a fetch grant after MAX_DATA_STREAK data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wd,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        busy
);

  localparam int unsigned LAT_W    = $clog2(ARB_MAX_LATENCY + 1);
  localparam int unsigned STREAK_W = $clog2(ARB_MAX_STREAK + 1);
  localparam logic [LAT_W-1:0]    LAT_INIT   = LAT_W'(LATENCY);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_e             state;
  arb_owner_e             owner;
  logic                   owner_we;
  logic [LAT_W-1:0]       lat_cnt;
  logic [STREAK_W-1:0]    streak;
  logic                   resp;
  logic                   window;
  logic                   pick_if;
  logic                   pick_d;

  // Grant window and winner selection; reset closes the window so no grant leaks out
  always_comb begin
    resp    = (state == ARB_WAIT) && (lat_cnt == LAT_W'(1));
    window  = !rst && ((state == ARB_IDLE) || resp);
    pick_d  = window && d_req && !(if_req && (streak == STREAK_MAX));
    pick_if = window && if_req && !pick_d;
  end

  // Memory request mux: winner's fields pass straight through, idle bus is zero
  always_comb begin
    mem_en    = pick_if | pick_d;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wstrb = '0;
    mem_wd    = '0;
    if (pick_d) begin
      mem_addr  = d_addr;
      mem_we    = d_we;
      mem_wstrb = d_wstrb;
      mem_wd    = d_wd;
    end else if (pick_if) begin
      mem_addr  = if_addr;
    end
  end

  // Response routing back to the owner; stores acknowledge with zero data
  always_comb begin
    if_gnt    = pick_if;
    d_gnt     = pick_d;
    if_rvalid = !rst && resp && (owner == OWN_IF);
    d_rvalid  = !rst && resp && (owner == OWN_D);
    if_rdata  = if_rvalid ? mem_rd : '0;
    d_rdata   = (d_rvalid && !owner_we) ? mem_rd : '0;
    busy      = !rst && (state == ARB_WAIT);
  end

  // Transaction FSM: a grant in the response cycle chains straight into a new WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      owner    <= OWN_NONE;
      owner_we <= 1'b0;
      lat_cnt  <= '0;
    end else if (pick_if || pick_d) begin
      state    <= ARB_WAIT;
      lat_cnt  <= LAT_INIT;
      owner    <= pick_d ? OWN_D : OWN_IF;
      owner_we <= pick_d && d_we;
    end else if (state == ARB_WAIT) begin
      if (lat_cnt == LAT_W'(1)) begin
        state    <= ARB_IDLE;
        owner    <= OWN_NONE;
        owner_we <= 1'b0;
        lat_cnt  <= '0;
      end else begin
        lat_cnt  <= lat_cnt - LAT_W'(1);
      end
    end
  end

  // Consecutive data grants while fetch waits; saturates at the limit
  always_ff @(posedge clk) begin
    if (rst || !if_req || pick_if) begin
      streak <= '0;
    end else if (pick_d && (streak != STREAK_MAX)) begin
      streak <= streak + STREAK_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with an emulated latency RAM and a
// transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int MAXS = 2;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_we;
  logic [3:0]  d_wstrb;
  logic [31:0] d_wd;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        busy;
  logic [138:0] all_outs;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          due;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
  } txn_t;
  txn_t q[$];

  mem_port_arbiter #(
    .LATENCY(LAT),
    .MAX_DATA_STREAK(MAXS)
  ) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wstrb(d_wstrb), .d_wd(d_wd),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy)
  );

  assign all_outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                     mem_en, mem_addr, mem_we, mem_wstrb, mem_wd, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents are a fixed function of the address.
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return a ^ 32'h8000_0013;
  endfunction

  // Read data appears LAT cycles after the mem_en cycle.
  logic [31:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_en ? ram_word(mem_addr) : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rd = rd_pipe[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    if_req = 0; if_addr = '0;
    d_req = 0; d_addr = '0; d_we = 0; d_wstrb = '0; d_wd = '0;
  endtask

  task automatic test_reset();
    rst = 1; if_req = 1; d_req = 1; if_addr = $urandom; d_addr = $urandom;
    d_we = 1; d_wstrb = 4'hF; d_wd = $urandom;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (all_outs !== '0) begin
        errors++; $display("FAIL reset_outputs cyc%0d: got %h required 0", i, all_outs);
      end
      tick();
    end
    clear_reqs();
    tick();
    rst = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++;
    if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b required 0", mem_en); end
    tick();
  endtask

  task automatic test_single_fetch();
    if_req = 1; if_addr = 32'h8000_0000;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      errors++; $display("FAIL fetch_gnt: got if=%b d=%b required if=1 d=0", if_gnt, d_gnt);
    end
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin
      errors++; $display("FAIL fetch_mem: got en=%b addr=%h we=%b strb=%h required 1 80000000 0 0",
                         mem_en, mem_addr, mem_we, mem_wstrb);
    end
    for (int t = 1; t <= LAT; t++) begin
      tick();
      if (t == 1) if_req = 0;
      @(negedge clk);
      checks++;
      if (if_rvalid !== (t == LAT)) begin
        errors++; $display("FAIL fetch_rvalid t=%0d: got %b required %b", t, if_rvalid, t == LAT);
      end
      checks++;
      if (d_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_d_rvalid t=%0d: got %b required 0", t, d_rvalid); end
      if (t == LAT) begin
        checks++;
        if (if_rdata !== 32'h0000_0013) begin
          errors++; $display("FAIL fetch_rdata: got %h required 00000013", if_rdata);
        end
      end
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL fetch_busy_after: got %b required 0", busy); end
    tick();
  endtask

  task automatic test_priority();
    int g_if, rv_d, rv_if, n_d, n_if;
    bit drop_if;
    g_if = -1; rv_d = -1; rv_if = -1; n_d = 0; n_if = 0; drop_if = 0;
    if_req = 1; if_addr = 32'h40; d_req = 1; d_addr = 32'h100; d_we = 0;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL prio_first: got d=%b if=%b addr=%h required 1 0 00000100", d_gnt, if_gnt, mem_addr);
    end
    for (int t = 1; t <= 3*LAT + 2; t++) begin
      tick();
      if (t == 1) d_req = 0;
      if (drop_if) if_req = 0;
      @(negedge clk);
      if (if_gnt === 1'b1 && g_if < 0) begin g_if = t; drop_if = 1; end
      if (d_rvalid === 1'b1) begin
        rv_d = t; n_d++;
        checks++;
        if (d_rdata !== ram_word(32'h100)) begin
          errors++; $display("FAIL prio_d_rdata: got %h required %h", d_rdata, ram_word(32'h100));
        end
      end
      if (if_rvalid === 1'b1) begin
        rv_if = t; n_if++;
        checks++;
        if (if_rdata !== ram_word(32'h40)) begin
          errors++; $display("FAIL prio_if_rdata: got %h required %h", if_rdata, ram_word(32'h40));
        end
      end
    end
    checks++;
    if (g_if != LAT) begin errors++; $display("FAIL prio_if_gnt_cycle: got %0d required %0d", g_if, LAT); end
    checks++;
    if (rv_d != LAT || n_d != 1) begin
      errors++; $display("FAIL prio_d_rvalid: got cycle %0d count %0d required %0d 1", rv_d, n_d, LAT);
    end
    checks++;
    if (rv_if != 2*LAT || n_if != 1) begin
      errors++; $display("FAIL prio_if_rvalid: got cycle %0d count %0d required %0d 1", rv_if, n_if, 2*LAT);
    end
    tick();
  endtask

  task automatic test_store();
    d_req = 1; d_addr = 32'h200; d_we = 1; d_wstrb = 4'b0011; d_wd = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt: got %b required 1", d_gnt); end
    checks++;
    if ({mem_en, mem_we, mem_wstrb, mem_wd, mem_addr} !== {1'b1, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h200}) begin
      errors++; $display("FAIL store_mem: got en=%b we=%b strb=%b wd=%h addr=%h required 1 1 0011 deadbeef 00000200",
                         mem_en, mem_we, mem_wstrb, mem_wd, mem_addr);
    end
    for (int t = 1; t <= LAT; t++) begin
      tick();
      if (t == 1) begin d_req = 0; d_we = 0; d_wstrb = '0; d_wd = '0; end
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0) begin errors++; $display("FAIL store_we_pulse t=%0d: got %b required 0", t, mem_we); end
      checks++;
      if (d_rvalid !== (t == LAT)) begin
        errors++; $display("FAIL store_rvalid t=%0d: got %b required %b", t, d_rvalid, t == LAT);
      end
      if (t == LAT) begin
        checks++;
        if (d_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata: got %h required 00000000", d_rdata); end
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    if_req = 1; if_addr = 32'h300;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b required 1", if_gnt); end
    tick();
    if_req = 0; rst = 1;
    @(negedge clk);
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL rmid_outputs: got %h required 0", all_outs); end
    tick();
    rst = 0; if_req = 1; if_addr = 32'h304;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_regrant: got gnt=%b busy=%b required 1 0", if_gnt, busy);
    end
    for (int t = 1; t <= LAT + 2; t++) begin
      tick();
      if (t == 1) if_req = 0;
      @(negedge clk);
      checks++;
      if (if_rvalid !== (t == LAT)) begin
        errors++; $display("FAIL rmid_rvalid t=%0d: got %b required %b", t, if_rvalid, t == LAT);
      end
      if (t == LAT) begin
        checks++;
        if (if_rdata !== ram_word(32'h304)) begin
          errors++; $display("FAIL rmid_rdata: got %h required %h", if_rdata, ram_word(32'h304));
        end
      end
    end
    tick();
  endtask

  task automatic test_streak();
    int n, dcount, last_g;
    bit exp_d, new_d, new_if;
    n = 0; dcount = 0; last_g = -1; new_d = 0; new_if = 0;
    if_req = 1; if_addr = {$urandom} & ~32'h3; d_req = 1; d_addr = $urandom; d_we = 0;
    for (int t = 0; t < 6*LAT + 6 && n < 6; t++) begin
      if (t > 0) tick();
      if (new_d) d_addr = $urandom;
      if (new_if) if_addr = {$urandom} & ~32'h3;
      new_d = 0; new_if = 0;
      @(negedge clk);
      if (if_gnt === 1'b1 || d_gnt === 1'b1) begin
        exp_d = (dcount != MAXS);
        checks++;
        if (d_gnt !== exp_d || if_gnt !== !exp_d) begin
          errors++; $display("FAIL streak_order grant%0d: got d=%b if=%b required d=%b if=%b",
                             n, d_gnt, if_gnt, exp_d, !exp_d);
        end
        if (last_g >= 0) begin
          checks++;
          if (t - last_g != LAT) begin
            errors++; $display("FAIL streak_spacing grant%0d: got %0d required %0d", n, t - last_g, LAT);
          end
        end
        last_g = t; n++;
        dcount = exp_d ? dcount + 1 : 0;
        new_d = exp_d; new_if = !exp_d;
      end
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL streak_count: got %0d grants required 6", n); end
    tick();
    clear_reqs();
    repeat (LAT + 1) tick();
  endtask

  task automatic test_back_to_back();
    int ng, nrv;
    bit gflag;
    logic [31:0] exp_a [$];
    int exp_due [$];
    ng = 0; nrv = 0; gflag = 0;
    if_req = 1; if_addr = 32'h1000;
    for (int t = 0; t < 9*LAT + 4; t++) begin
      if (t > 0) tick();
      if (ng == 8) if_req = 0;
      else if (gflag) if_addr = if_addr + 32'd4;
      gflag = 0;
      @(negedge clk);
      if (if_gnt === 1'b1) begin
        checks++;
        if (t != ng*LAT) begin errors++; $display("FAIL b2b_gnt_cycle grant%0d: got %0d required %0d", ng, t, ng*LAT); end
        exp_a.push_back(if_addr); exp_due.push_back(t + LAT);
        ng++; gflag = 1;
      end
      if (if_rvalid === 1'b1) begin
        checks++;
        if (exp_a.size() == 0) begin
          errors++; $display("FAIL b2b_rvalid: got unexpected rvalid at %0d required none", t);
        end else begin
          if (exp_due[0] != t || if_rdata !== ram_word(exp_a[0])) begin
            errors++; $display("FAIL b2b_rdata: got %h at %0d required %h at %0d",
                               if_rdata, t, ram_word(exp_a[0]), exp_due[0]);
          end
          void'(exp_a.pop_front()); void'(exp_due.pop_front());
          nrv++;
        end
      end
    end
    checks++;
    if (ng != 8 || nrv != 8) begin errors++; $display("FAIL b2b_counts: got gnt=%0d rvalid=%0d required 8 8", ng, nrv); end
    tick();
  endtask

  task automatic test_random();
    int free_at, last_g, streak_m;
    bit if_taken, d_taken, exp_if, exp_d, exp_rv_if, exp_rv_d, exp_busy;
    logic [31:0] exp_data;
    txn_t tx;
    free_at = 0; last_g = -1; streak_m = 0; if_taken = 0; d_taken = 0;
    q.delete();
    for (int t = 0; t < 400; t++) begin
      if (t > 0) tick();
      if (if_req && !if_taken) begin
        if ($urandom_range(0, 9) == 0) if_req = 0;
      end else begin
        if_req = ($urandom_range(0, 9) < 6);
        if_addr = {$urandom} & ~32'h3;
      end
      if (d_req && !d_taken) begin
        if ($urandom_range(0, 9) == 0) d_req = 0;
      end else begin
        d_req = ($urandom_range(0, 9) < 6);
        d_addr = $urandom; d_we = $urandom_range(0, 1);
        d_wstrb = 4'($urandom); d_wd = $urandom;
      end
      @(negedge clk);
      exp_d  = (t >= free_at) && d_req && !(if_req && streak_m == MAXS);
      exp_if = (t >= free_at) && if_req && !exp_d;
      checks++;
      if ({if_gnt, d_gnt} !== {exp_if, exp_d}) begin
        errors++; $display("FAIL rand_gnt t=%0d: got if=%b d=%b required if=%b d=%b", t, if_gnt, d_gnt, exp_if, exp_d);
      end
      if (exp_if || exp_d) begin
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== (exp_d ? d_addr : if_addr) || mem_we !== (exp_d && d_we)) begin
          errors++; $display("FAIL rand_mem t=%0d: got en=%b addr=%h we=%b required 1 %h %b",
                             t, mem_en, mem_addr, mem_we, exp_d ? d_addr : if_addr, exp_d && d_we);
        end
      end
      exp_rv_if = 0; exp_rv_d = 0; exp_data = '0;
      if (q.size() > 0 && q[0].due == t) begin
        tx = q.pop_front();
        exp_rv_d = tx.is_d; exp_rv_if = !tx.is_d;
        exp_data = tx.we ? 32'h0 : ram_word(tx.addr);
      end
      checks++;
      if ({if_rvalid, d_rvalid} !== {exp_rv_if, exp_rv_d}) begin
        errors++; $display("FAIL rand_rvalid t=%0d: got if=%b d=%b required if=%b d=%b",
                           t, if_rvalid, d_rvalid, exp_rv_if, exp_rv_d);
      end
      if (exp_rv_if || exp_rv_d) begin
        checks++;
        if ((exp_rv_if ? if_rdata : d_rdata) !== exp_data) begin
          errors++; $display("FAIL rand_rdata t=%0d: got %h required %h", t, exp_rv_if ? if_rdata : d_rdata, exp_data);
        end
      end
      exp_busy = (last_g >= 0) && (t > last_g) && (t <= last_g + LAT);
      checks++;
      if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy t=%0d: got %b required %b", t, busy, exp_busy); end
      if (exp_if || exp_d) begin
        last_g = t; free_at = t + LAT;
        tx.due = t + LAT; tx.is_d = exp_d; tx.we = exp_d && d_we; tx.addr = exp_d ? d_addr : if_addr;
        q.push_back(tx);
      end
      if (!if_req || exp_if) streak_m = 0;
      else if (exp_d && streak_m < MAXS) streak_m++;
      if_taken = exp_if; d_taken = exp_d;
    end
    tick();
    clear_reqs();
    repeat (LAT + 1) tick();
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    clear_reqs();
    rst = 1;
    test_reset();
    test_single_fetch();
    test_priority();
    test_store();
    test_reset_mid();
    test_streak();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch requester and the load/store (data) requester, so the core can move off the dual-port RAM model.
- Holds at most one transaction in flight and routes each response back to the requester that issued it.
- Data has priority. A streak limiter stops fetch from being starved.
- Sits between the pc/controller request sources and the ram.

Parameters:
- LATENCY, 1, cycles from the mem_en cycle to a valid mem_rd (legal range 1..4).
- MAX_DATA_STREAK, 4, maximum consecutive data grants while if_req is pending before fetch is forced (legal range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request; held until granted
- if_addr  in  32  fetch address, word aligned
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  one-cycle pulse, fetch data valid
- if_rdata  out  32  fetch data
- d_req  in  1  data request; held until granted
- d_addr  in  32  data address
- d_we  in  1  1 = store
- d_wstrb  in  4  byte enables for a store
- d_wd  in  32  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse, load data or store acknowledge
- d_rdata  out  32  load data; 0 for a store acknowledge
- mem_en  out  1  memory access strobe
- mem_addr  out  32  memory address
- mem_we  out  1  memory write enable
- mem_wstrb  out  4  memory byte enables
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data, valid LATENCY cycles after mem_en
- busy  out  1  a transaction is in flight

Behaviour:
- States: IDLE and WAIT, with a registered owner (OWN_NONE, OWN_IF or OWN_D) and a down-counter lat_cnt.
- Reset (rst high at a clk edge):
  - State goes to IDLE, owner to OWN_NONE, lat_cnt and the streak counter to 0.
  - While rst is high, all outputs are 0: gnt, rvalid, mem_en, mem_we, mem_wstrb, busy, and all data buses.
- Reset mid-transaction abandons it. No rvalid is ever produced for it.
- Grant window (combinational): open when state is IDLE, or when state is WAIT and lat_cnt == 1 (the response cycle).
- In the grant window, winner selection:
  - Only one req high: that requester wins.
  - Both high: data wins, unless streak == MAX_DATA_STREAK, in which case fetch wins.
- Winner cycle:
  - The winner's gnt = 1, mem_en = 1, and mem_addr/we/wstrb/wd are driven combinationally from the winner.
  - Fetch drives mem_we = 0 and mem_wstrb = 0.
  - Next state is WAIT, lat_cnt = LATENCY, owner = winner, and the registered owner_we = the winner's we.
- WAIT: lat_cnt decrements each cycle. When lat_cnt == 1:
  - The owner's rvalid = 1 and rdata = mem_rd (or 0 if owner_we).
  - If no new grant happens that cycle, the next state is IDLE and owner goes to OWN_NONE.
- A response and a new grant in the same cycle is legal. Sustained throughput is one transaction per LATENCY cycles.
- Timing for LATENCY = 1: grant at cycle N, rvalid at cycle N+1.
- Streak counter:
  - Increments on a data grant while if_req is high.
  - Clears on any fetch grant, and whenever if_req is low.
  - Saturates at MAX_DATA_STREAK.
- busy = (state == WAIT).
- gnt is never asserted outside the grant window.
- Requests and rvalid are single-cycle events per grant. Exactly one rvalid follows each gnt.
- Requesters must hold addr/we/wd stable while req is high and not yet granted.
- Deasserting req before gnt is allowed; the request is dropped without side effects.
- No address decoding or alignment checking is done here.

Decomposition:
- Shared riscv types package gets:
  - arb_owner_e {OWN_NONE, OWN_IF, OWN_D}
  - arb_state_e {ARB_IDLE, ARB_WAIT}
  - the localparam for the maximum legal LATENCY.
- Single module. Winner selection stays inline in an always_comb, since it is too small to justify a sub-module.

Test Plan:
1. LATENCY=1, if_req with if_addr=0x8000_0000 and mem_rd=0x0000_0013 at N+1 -> if_gnt at N, mem_en=1 with mem_addr=0x8000_0000 at N, if_rvalid=1 with if_rdata=0x13 at N+1, d_rvalid stays 0.
2. LATENCY=2, if_req and d_req (load 0x100) both high at N -> d_gnt at N, if_gnt stalled to N+2, d_rvalid at N+2, if_rvalid at N+4.
3. MAX_DATA_STREAK=2, if_req and d_req held high continuously -> grant sequence D, D, IF, D, D, IF; streak resets after each IF grant.
4. Store d_we=1, d_wstrb=4'b0011, d_wd=0xDEAD_BEEF at 0x200 -> mem_we=1, mem_wstrb=0011, mem_wd=0xDEADBEEF for one cycle; d_rvalid after LATENCY cycles with d_rdata=0.
5. LATENCY=3, rst pulsed in the cycle after a fetch grant -> outputs 0 during reset, no if_rvalid ever appears, and a new request after reset is granted immediately from IDLE.
6. LATENCY=1, fetch requests back-to-back for 8 cycles -> if_gnt every cycle, if_rvalid every cycle from the second onward, each rdata matching the address issued one cycle earlier.
